imem_loader: RTL

Program loader sitting directly upstream of the pipelined CPU's instruction memory. It accepts a byte stream over a valid/ready handshake and packs it into 32-bit big-endian instruction words. It writes each word into consecutive instruction-RAM locations starting at word 0 and holds the CPU in reset until the load completes. A load ends when the halt word 32'hFFFFFFFF has been written, or when the RAM is full.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_loader_if.sv | 14 +
 rtl/imem_byte_packer.sv | 49 ++++
 rtl/imem_loader.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
//   state_e    : loader FSM states
//   HALT_WORD  : word that terminates a load (it is still written to RAM)
//   BYTE_CNT_W : width of the byte-within-word counter
package imem_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_WRITE   = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned WORD_W     = 32;
   localparam int unsigned BYTE_CNT_W = 2;

   localparam logic [WORD_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the loader.
//   in_valid : source presents a byte
//   in_data  : stream byte, first byte of a word is the MSB
//   in_ready : loader accepts the byte this cycle
interface imem_loader_if;
   import imem_loader_pkg::*;

   logic              in_valid;
   logic [BYTE_W-1:0] in_data;
   logic              in_ready;

   modport master (output in_valid, output in_data, input  in_ready);
   modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/imem_byte_packer.sv
// Packs a byte stream into big-endian 32-bit words.
//   clk, reset : clock, asynchronous active-low reset
//   clr        : discard any partial word and restart at byte 0
//   shift_en   : accept byte_in this cycle
//   byte_in    : incoming byte, inserted at [7:0] after a left shift
//   word_out   : current contents of the shift register
//   last_byte  : the next accepted byte completes a word
module imem_byte_packer
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              shift_en,
   input  logic [BYTE_W-1:0] byte_in,
   output logic [WORD_W-1:0] word_out,
   output logic              last_byte
);

   logic [WORD_W-1:0]     sr_q, sr_d;
   logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;

   // Shift left so the first byte of a word ends up in [31:24]; counter wraps at 4.
   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (clr) begin
         sr_d  = '0;
         cnt_d = '0;
      end else if (shift_en) begin
         sr_d  = {sr_q[WORD_W-BYTE_W-1:0], byte_in};
         cnt_d = cnt_q + BYTE_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

   assign word_out  = sr_q;
   assign last_byte = (cnt_q == '1);

endmodule

// File: rtl/imem_loader.sv
// Program loader: packs a byte stream into words, writes them to instruction
// RAM from word 0, and holds the CPU in reset until the halt word or a full RAM.
//   clk, reset  : clock, asynchronous active-low reset
//   start       : begin a load (honoured in IDLE or DONE only)
//   stream      : byte valid/ready channel (slave side)
//   imem_we/addr/wdata : one-cycle RAM write per word
//   cpu_reset   : high while the load is not done
//   done        : load finished
//   overflow    : RAM filled without a halt word, sticky until next start
//   word_count  : words written including the halt word
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned DEPTH  = 512,
   parameter int unsigned ADDR_W = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   imem_loader_if.slave      stream,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [WORD_W-1:0] imem_wdata,
   output logic              cpu_reset,
   output logic              done,
   output logic              overflow,
   output logic [ADDR_W:0]   word_count
);

   localparam int unsigned WC_W = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [WC_W-1:0]   wc_q, wc_d;
   logic              ovf_q, ovf_d;
   logic              in_ready_q, in_ready_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic              done_q, done_d;
   logic              cpu_reset_q, cpu_reset_d;

   logic              accept_c;
   logic              clr_c;
   logic              last_byte;
   logic [WORD_W-1:0] packed_word;

   assign accept_c = stream.in_valid && in_ready_q;

   imem_byte_packer u_packer (
      .clk       (clk),
      .reset     (reset),
      .clr       (clr_c),
      .shift_en  (accept_c),
      .byte_in   (stream.in_data),
      .word_out  (packed_word),
      .last_byte (last_byte)
   );

   // Next state; registered outputs are derived from the next state so they
   // line up with the state they describe.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wc_d    = wc_q;
      ovf_d   = ovf_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      clr_c   = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_COLLECT;
               clr_c   = 1'b1;
               addr_d  = '0;
               wc_d    = '0;
               ovf_d   = 1'b0;
            end
         end
         ST_COLLECT: begin
            // The 4th byte is still on the bus, so splice it in for the write data.
            if (accept_c && last_byte) begin
               state_d = ST_WRITE;
               we_d    = 1'b1;
               waddr_d = addr_q;
               wdata_d = {packed_word[WORD_W-BYTE_W-1:0], stream.in_data};
            end
         end
         ST_WRITE: begin
            wc_d = wc_q + WC_W'(1);
            if (packed_word == HALT_WORD) begin
               state_d = ST_DONE;
            end else if (addr_q == LAST_ADDR) begin
               state_d = ST_DONE;
               ovf_d   = 1'b1;
            end else begin
               state_d = ST_COLLECT;
               addr_d  = addr_q + ADDR_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      in_ready_d  = (state_d == ST_COLLECT);
      done_d      = (state_d == ST_DONE);
      cpu_reset_d = (state_d != ST_DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         wc_q        <= '0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b0;
         we_q        <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         done_q      <= 1'b0;
         cpu_reset_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wc_q        <= wc_d;
         ovf_q       <= ovf_d;
         in_ready_q  <= in_ready_d;
         we_q        <= we_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         done_q      <= done_d;
         cpu_reset_q <= cpu_reset_d;
      end
   end

   assign stream.in_ready = in_ready_q;
   assign imem_we         = we_q;
   assign imem_addr       = waddr_q;
   assign imem_wdata      = wdata_q;
   assign cpu_reset       = cpu_reset_q;
   assign done            = done_q;
   assign overflow        = ovf_q;
   assign word_count      = wc_q;

endmodule
